// File: rtl/pps_time_tx.sv
// PPS pulse generator and framed serial time transmitter (sysclk domain).
// Each accepted flag fires a fixed-width pulse and sends {1, sec[31:0], parity, 0}.
module pps_time_tx #(
  parameter int BIT_CLKS   = 16,
  parameter int PPS_WIDTH  = 1000,
  parameter     SYSCLKTYPE = "NONE"
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        en_i,
  input  logic        pps_flag_i,
  input  logic [31:0] cur_sec_i,
  input  logic        clr_overrun_i,
  output logic        pps_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [15:0] frame_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] TMR_LOAD = 16'(BIT_CLKS - 1);
  localparam logic [23:0] PPS_LOAD = 24'(PPS_WIDTH - 1);

  state_t      state_q;
  logic [15:0] tmr_q;
  logic [4:0]  idx_q;
  logic [31:0] sec_q;
  (* clock_type = SYSCLKTYPE *) logic tx_q;
  (* clock_type = SYSCLKTYPE *) logic pps_q;
  logic [23:0] pps_cnt_q;
  logic        overrun_q;
  logic [15:0] frame_cnt_q;

  logic        accept_d;
  logic        bit_end_d;
  logic        last_stop_d;
  logic        busy_d;
  logic [31:0] sec_d;

  assign accept_d    = en_i & pps_flag_i;
  assign bit_end_d   = (tmr_q == 16'd0);
  assign busy_d      = (state_q != S_IDLE);
  assign last_stop_d = (state_q == S_STOP) && bit_end_d;
  assign sec_d       = cur_sec_i + 32'd1;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      sec_q       <= '0;
      tx_q        <= 1'b0;
      pps_q       <= 1'b0;
      pps_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else if (!en_i) begin
      // Disable aborts everything in flight but keeps the sticky status.
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b0;
      pps_q     <= 1'b0;
      pps_cnt_q <= '0;
      if (clr_overrun_i) overrun_q <= 1'b0;
    end else begin
      if (accept_d) begin
        pps_q     <= 1'b1;
        pps_cnt_q <= PPS_LOAD;
      end else if (pps_cnt_q != 24'd0) begin
        pps_cnt_q <= pps_cnt_q - 24'd1;
      end else begin
        pps_q <= 1'b0;
      end

      if (last_stop_d) frame_cnt_q <= frame_cnt_q + 16'd1;

      // A flag in the final stop cycle chains cleanly; anywhere else mid-frame is an overrun.
      if (accept_d && busy_d && !last_stop_d) overrun_q <= 1'b1;
      else if (clr_overrun_i)                 overrun_q <= 1'b0;

      if (accept_d) begin
        state_q <= S_START;
        tmr_q   <= TMR_LOAD;
        idx_q   <= 5'd31;
        sec_q   <= sec_d;
        tx_q    <= 1'b1;
      end else if (state_q == S_IDLE) begin
        tx_q <= 1'b0;
      end else if (!bit_end_d) begin
        tmr_q <= tmr_q - 16'd1;
      end else begin
        tmr_q <= TMR_LOAD;
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            idx_q   <= 5'd31;
            tx_q    <= sec_q[31];
          end
          S_DATA: begin
            if (idx_q == 5'd0) begin
              state_q <= S_PARITY;
              tx_q    <= ^sec_q;
            end else begin
              idx_q <= idx_q - 5'd1;
              tx_q  <= sec_q[idx_q - 5'd1];
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            tx_q    <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            tx_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pps_o         = pps_q;
  assign tx_o          = tx_q;
  assign busy_o        = busy_d;
  assign overrun_o     = overrun_q;
  assign frame_count_o = frame_cnt_q;

endmodule
